// File: rtl/handshake_tx_arbiter.sv
// handshake_tx_arbiter: round-robin arbiter over NUM_CLIENTS requesters feeding
// a single 4-phase req/ack sender toward a receiver in another clock domain.

// Per-client slice: flags an all-ones word and produces the accept pulse.
module handshake_tx_arbiter_lane #(
  parameter int DATA_WIDTH = 4,
  parameter int GW         = 2,
  parameter int IDX        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [GW-1:0]         sel,
  input  logic                  take,
  output logic                  ones,
  output logic                  ready
);
  localparam logic [GW-1:0] MY_ID = GW'(IDX);

  assign ones = &word;

  // one-cycle accept pulse on the edge this lane's word is taken or dropped
  always_ff @(posedge clk) begin
    if (rst) ready <= 1'b0;
    else     ready <= take && (sel == MY_ID);
  end
endmodule

module handshake_tx_arbiter #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_CLIENTS = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            cli_valid,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_data,
  output logic [NUM_CLIENTS-1:0]            cli_ready,
  output logic                              req_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  input  logic                              ack_in,
  output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id,
  output logic                              busy,
  output logic                              done_pulse,
  output logic                              reject_pulse,
  output logic                              timeout_pulse
);
  localparam int GW = $clog2(NUM_CLIENTS);
  localparam int SW = GW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO      = CW'(ACK_TIMEOUT);
  localparam logic [GW-1:0] LAST_CLI = GW'(NUM_CLIENTS - 1);
  localparam logic [SW-1:0] NCLI     = SW'(NUM_CLIENTS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REQ_HIGH     = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] cli_words;
  logic [NUM_CLIENTS-1:0]                 lane_ones;
  logic [GW-1:0]                          last_grant;
  logic [GW-1:0]                          sel;
  logic [GW-1:0]                          cand;
  logic [SW-1:0]                          sum;
  logic                                   found;
  logic                                   ack_m, ack_s;
  logic [CW-1:0]                          wait_cnt;
  logic                                   timed_out;
  logic                                   do_grant, do_reject, do_tmo, do_done;
  logic                                   take;
  logic [DATA_WIDTH-1:0]                  sel_word;
  logic                                   sel_ones;

  assign cli_words = cli_data;
  assign sel_word  = cli_words[sel];
  assign sel_ones  = lane_ones[sel];
  assign take      = do_grant | do_reject;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
    handshake_tx_arbiter_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .GW         (GW),
      .IDX        (i)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .word  (cli_words[i]),
      .sel   (sel),
      .take  (take),
      .ones  (lane_ones[i]),
      .ready (cli_ready[i])
    );
  end

  // two-flop synchronizer; nothing downstream looks at raw ack_in
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack_in;
      ack_s <= ack_m;
    end
  end

  // round-robin search starting one past the last served client
  always_comb begin
    sel   = last_grant;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      sum = {1'b0, last_grant} + SW'(k);
      if (sum >= NCLI) sum = sum - NCLI;
      cand = sum[GW-1:0];
      if (!found && cli_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // next-state and one-shot event decode
  always_comb begin
    state_nx  = state;
    do_grant  = 1'b0;
    do_reject = 1'b0;
    do_tmo    = 1'b0;
    do_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          if (sel_ones) begin
            do_reject = 1'b1;
          end else begin
            do_grant = 1'b1;
            state_nx = REQ_HIGH;
          end
        end
      end
      REQ_HIGH: begin
        // a real ack wins over a coincident timeout
        if (ack_s) begin
          state_nx = WAIT_ACK_LOW;
        end else if (wait_cnt == TMO) begin
          do_tmo   = 1'b1;
          state_nx = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_s) begin
          state_nx = IDLE;
          do_done  = !timed_out;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register, busy flag and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      reject_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      busy          <= (state_nx != IDLE);
      done_pulse    <= do_done;
      reject_pulse  <= do_reject;
      timeout_pulse <= do_tmo;
    end
  end

  // grant bookkeeping: word/id are captured once and held until back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LAST_CLI;
      data_out   <= '0;
      grant_id   <= '0;
    end else begin
      if (take) last_grant <= sel;
      if (do_grant) begin
        data_out <= sel_word;
        grant_id <= sel;
      end
    end
  end

  // request line, ack wait counter and timeout flag for the current transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      req_out   <= 1'b0;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (do_grant) begin
      req_out   <= 1'b1;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (state == REQ_HIGH) begin
      wait_cnt <= wait_cnt + CW'(1);
      if (state_nx == WAIT_ACK_LOW) req_out <= 1'b0;
      if (do_tmo) timed_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_handshake_tx_arbiter.sv
// Directed bench for handshake_tx_arbiter: scoreboard of expected grants,
// 4-phase receiver model, and pulse-rule monitor.
module tb_handshake_tx_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  cli_valid;
  logic [15:0] cli_data;
  logic [3:0]  cli_ready;
  logic        req_out;
  logic [3:0]  data_out;
  logic        ack_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done_pulse, reject_pulse, timeout_pulse;

  handshake_tx_arbiter #(
    .DATA_WIDTH  (4),
    .NUM_CLIENTS (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cli_valid     (cli_valid),
    .cli_data      (cli_data),
    .cli_ready     (cli_ready),
    .req_out       (req_out),
    .data_out      (data_out),
    .ack_in        (ack_in),
    .grant_id      (grant_id),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .reject_pulse  (reject_pulse),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct {
    logic [3:0] rdy;
    logic [1:0] id;
    logic [3:0] data;
    logic       rej;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_done = 0, n_rej = 0, n_tmo = 0;
  int ack_delay = 3;             // 0: receiver never acks
  int rcv_cnt = 0;
  int ack_rise_cyc = 0, req_fall_cyc = 0;
  int req_len = 0, last_req_len = 0;
  logic [3:0] held = '0;
  logic busy_q = 0, req_q = 0, done_q = 0, rej_q = 0, tmo_q = 0;
  logic [3:0] rdy_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic [3:0] r, input logic [1:0] id,
                                   input logic [3:0] d, input logic rej);
    exp_t e;
    e.rdy = r; e.id = id; e.data = d; e.rej = rej;
    sb.push_back(e);
  endfunction

  task automatic wait_ready(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (cli_ready != 0) seen = 1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic wait_idle(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // 4-phase receiver: raise ack ack_delay cycles after req, drop it once req falls
  initial forever begin
    @(negedge clk);
    if (!req_out) begin
      ack_in  = 1'b0;
      rcv_cnt = 0;
    end else if (!ack_in && ack_delay > 0) begin
      rcv_cnt++;
      if (rcv_cnt == ack_delay) begin
        ack_in = 1'b1;
        ack_rise_cyc = cyc + 1;  // first edge that samples the new level
      end
    end
  end

  // monitor: scoreboard pop on each accept pulse, pulse rules, data hold
  initial forever begin
    exp_t e;
    @(negedge clk);
    chk("pulse_excl", 32'($countones({done_pulse, reject_pulse, timeout_pulse}) <= 1), 1);
    chk("pulse_1cyc", {28'b0, done_pulse & done_q, reject_pulse & rej_q,
                       timeout_pulse & tmo_q, |(cli_ready & rdy_q)}, 0);
    n_done += 32'(done_pulse);
    n_rej  += 32'(reject_pulse);
    n_tmo  += 32'(timeout_pulse);
    if (cli_ready != 0) begin
      chk("grant_gap", 32'(busy_q), 0);
      if (sb.size() == 0) chk("unexpected_grant", 32'(cli_ready), 0);
      else begin
        e = sb.pop_front();
        chk("grant_ready", 32'(cli_ready), 32'(e.rdy));
        chk("grant_reject", 32'(reject_pulse), 32'(e.rej));
        chk("grant_req", 32'(req_out), 32'(!e.rej));
        if (!e.rej) begin
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("grant_data", 32'(data_out), 32'(e.data));
          chk("grant_busy", 32'(busy), 1);
        end
      end
    end
    if (req_out && !req_q) begin
      req_len = 1;
      held    = data_out;
    end else if (req_out) begin
      req_len++;
    end else if (req_q) begin
      last_req_len = req_len;
      req_fall_cyc = cyc;
    end
    if (busy && busy_q) chk("data_stable", 32'(data_out), 32'(held));
    done_q = done_pulse; rej_q = reject_pulse; tmo_q = timeout_pulse;
    rdy_q  = cli_ready;  busy_q = busy; req_q = req_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, t0;
    rst = 1; cli_valid = '0; cli_data = '0; ack_in = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(cli_ready), 0);
    chk("rst_pulses", {29'b0, done_pulse, reject_pulse, timeout_pulse}, 0);
    rst = 0;
    @(negedge clk);

    // single transfer: client 0, word 5, ack 3 cycles after req
    ack_delay = 3;
    d0 = n_done;
    cli_data[3:0] = 4'h5; cli_valid = 4'b0001;
    push_exp(4'b0001, 2'd0, 4'h5, 1'b0);
    wait_ready("t1_ready_wait");
    cli_valid[0] = 1'b0;
    wait_idle("t1_idle_wait");
    @(negedge clk);
    chk("t1_ack_to_req_fall", 32'(req_fall_cyc - ack_rise_cyc), 2);
    chk("t1_done_count", 32'(n_done - d0), 1);
    chk("t1_busy", 32'(busy), 0);

    // all-ones word from client 1 is dropped
    r0 = n_rej;
    cli_data[7:4] = 4'hF; cli_valid = 4'b0010;
    push_exp(4'b0010, 2'd1, 4'hF, 1'b1);
    wait_ready("t3_ready_wait");
    cli_valid[1] = 1'b0;
    @(negedge clk);
    chk("t3_req_low", 32'(req_out), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_reject_count", 32'(n_rej - r0), 1);

    // search resumes at client 2; its word changes mid-transfer, then client 0
    cli_data[3:0] = 4'h7; cli_data[11:8] = 4'h3; cli_valid = 4'b0101;
    push_exp(4'b0100, 2'd2, 4'h3, 1'b0);
    push_exp(4'b0001, 2'd0, 4'h7, 1'b0);
    wait_ready("t4_ready_wait");
    cli_valid[2] = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      if (i == 1) cli_data[11:8] = 4'h9;
      if (busy) chk("t4_data_hold", 32'(data_out), 3);
    end
    chk("t4_idle", 32'(busy), 0);
    wait_ready("t4_ready2_wait");
    cli_valid[0] = 1'b0;
    wait_idle("t4_idle2_wait");

    // timeout: receiver never acks, ACK_TIMEOUT = 8
    ack_delay = 0;
    @(negedge clk);
    d0 = n_done; t0 = n_tmo;
    cli_data[7:4] = 4'h6; cli_valid = 4'b0010;
    push_exp(4'b0010, 2'd1, 4'h6, 1'b0);
    wait_ready("t5_ready_wait");
    cli_valid[1] = 1'b0;
    wait_idle("t5_idle_wait");
    @(negedge clk);
    chk("t5_req_high_cycles", 32'(last_req_len), 9);
    chk("t5_timeout_count", 32'(n_tmo - t0), 1);
    chk("t5_done_count", 32'(n_done - d0), 0);
    chk("t5_busy", 32'(busy), 0);

    // reset during REQ_HIGH (client 2, so last_grant is not the reset value)
    cli_data[11:8] = 4'hA; cli_valid = 4'b0100;
    push_exp(4'b0100, 2'd2, 4'hA, 1'b0);
    wait_ready("t6_ready_wait");
    cli_valid[2] = 1'b0;
    @(negedge clk);
    d0 = n_done; r0 = n_rej; t0 = n_tmo;
    rst = 1;
    @(posedge clk); #1;
    chk("t6_req", 32'(req_out), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(cli_ready), 0);
    chk("t6_pulses", {29'b0, done_pulse, reject_pulse, timeout_pulse}, 0);
    @(negedge clk);
    rst = 0;
    ack_delay = 3;
    @(negedge clk);
    chk("t6_no_pulse_count", 32'((n_done - d0) + (n_rej - r0) + (n_tmo - t0)), 0);

    // fairness after reset: all four held valid, client 0 goes first
    cli_data = {4'h4, 4'h3, 4'h2, 4'h1}; cli_valid = 4'b1111;
    push_exp(4'b0001, 2'd0, 4'h1, 1'b0);
    push_exp(4'b0010, 2'd1, 4'h2, 1'b0);
    push_exp(4'b0100, 2'd2, 4'h3, 1'b0);
    push_exp(4'b1000, 2'd3, 4'h4, 1'b0);
    push_exp(4'b0001, 2'd0, 4'h1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_ready("t7_ready_wait");
      if (k == 4) cli_valid = '0;
    end
    wait_idle("t7_idle_wait");
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/handshake_tx_arbiter.md
HANDSHAKE_TX_ARBITER -- requirements
Module: handshake_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 4, word width.
- NUM_CLIENTS, default 4, number of requesters, range 2..8.
- ACK_TIMEOUT, default 255, maximum cycles to wait for ack high.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- cli_valid  in  NUM_CLIENTS  per-client word pending.
- cli_data  in  NUM_CLIENTS*DATA_WIDTH  client i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- cli_ready  out  NUM_CLIENTS  one-cycle accept pulse to the granted client.
- req_out  out  1  4-phase request to the downstream receiver.
- data_out  out  DATA_WIDTH  word presented to the downstream receiver.
- ack_in  in  1  asynchronous acknowledge from the downstream receiver.
- grant_id  out  $clog2(NUM_CLIENTS)  index of the client currently served.
- busy  out  1  high whenever state is not IDLE.
- done_pulse  out  1  one-cycle pulse when a transfer completes normally.
- reject_pulse  out  1  one-cycle pulse when an all-ones word is dropped.
- timeout_pulse  out  1  one-cycle pulse when ack is not seen within ACK_TIMEOUT.

Function
REQ-003 ack_in SHALL pass through a 2-flop synchronizer (ack_s); only ack_s SHALL be used by the logic.
REQ-004 The FSM SHALL have exactly three states: IDLE, REQ_HIGH and WAIT_ACK_LOW.
REQ-005 Arbitration SHALL be round-robin. The search SHALL start at (last_grant+1) mod NUM_CLIENTS and pick the first set cli_valid bit.
REQ-006 In IDLE with any cli_valid set and a selected word not equal to all ones, the next edge SHALL:
- assert cli_ready[g] for exactly one cycle;
- register data_out and grant_id;
- set last_grant=g and req_out=1;
- enter REQ_HIGH.
REQ-007 In IDLE with a selected word equal to all ones, the next edge SHALL:
- pulse cli_ready[g] and reject_pulse for one cycle;
- set last_grant=g;
- leave req_out at 0 and stay in IDLE.
REQ-008 data_out SHALL remain stable from req_out rising until the FSM returns to IDLE.
REQ-009 In REQ_HIGH with ack_s=1, the next edge SHALL set req_out=0 and enter WAIT_ACK_LOW.
REQ-010 A wait counter SHALL clear on entry to REQ_HIGH and increment each cycle in REQ_HIGH. When it equals ACK_TIMEOUT with ack_s=0, the next edge SHALL set req_out=0, pulse timeout_pulse and enter WAIT_ACK_LOW.
REQ-011 In WAIT_ACK_LOW with ack_s=0, the next edge SHALL enter IDLE. It SHALL pulse done_pulse only if the transfer did not time out.
REQ-012 A new grant SHALL NOT occur earlier than the cycle after the FSM returns to IDLE, so there is at least one IDLE cycle between transfers.
REQ-013 Changes to cli_valid or cli_data while busy=1 SHALL have no effect on the transfer in progress.
REQ-014 A client whose cli_valid is still high after its cli_ready pulse SHALL be treated as presenting a new word.
REQ-015 done_pulse, reject_pulse, timeout_pulse and cli_ready SHALL never be high for more than one consecutive cycle.
REQ-016 At most one of done_pulse, reject_pulse and timeout_pulse SHALL be high in any cycle.

Reset
REQ-017 While rst=1 at a clock edge, every register SHALL take its reset value on that edge:
- state=IDLE;
- req_out, data_out, grant_id, busy, cli_ready, done_pulse, reject_pulse, timeout_pulse and the wait counter = 0;
- synchronizer flops = 0;
- last_grant=NUM_CLIENTS-1, so client 0 has first priority.
REQ-018 rst asserted mid-transfer SHALL drop req_out on the next edge, abandon the transfer and emit no pulses.

Verification
REQ-019 Single transfer:
- stimulus: cli_valid=0001, client 0 word 4'h5; receiver model acks 3 cycles after req.
- required: cli_ready[0] one pulse; req_out=1 and data_out=5; req_out falls 2 cycles after ack_in rises; done_pulse once; busy back to 0.
REQ-020 Fairness:
- stimulus: cli_valid=1111 held, words 1, 2, 3, 4.
- required: grant order 0, 1, 2, 3, 0; data_out sequence 1, 2, 3, 4, 1.
REQ-021 Invalid word:
- stimulus: cli_valid=0010, client 1 word 4'hF.
- required: cli_ready[1] pulse and reject_pulse; req_out stays 0; next grant starts at client 2.
REQ-022 Timeout:
- stimulus: ACK_TIMEOUT=8; ack_in held 0.
- required: req_out falls after 9 REQ_HIGH cycles; timeout_pulse once, no done_pulse; FSM returns to IDLE.
REQ-023 Reset mid-transfer:
- stimulus: rst=1 while in REQ_HIGH.
- required: next edge req_out=0, busy=0, no pulses; after rst release, client 0 is granted first.
REQ-024 Input change during transfer:
- stimulus: client 2 word changes from 3 to 9 while busy=1.
- required: data_out stays 3 until the FSM returns to IDLE.
